// File: rtl/video_timing_gen_if.sv
// Configuration and video-side signals of the raster timing generator.
// The generator drives through the master modport; the encoder/bench side uses slave.
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          cfg_load;
    logic [CW-1:0] cfg_h_sync;
    logic [CW-1:0] cfg_h_back;
    logic [CW-1:0] cfg_h_disp;
    logic [CW-1:0] cfg_h_front;
    logic [CW-1:0] cfg_v_sync;
    logic [CW-1:0] cfg_v_back;
    logic [CW-1:0] cfg_v_disp;
    logic [CW-1:0] cfg_v_front;
    logic          cfg_pending;
    logic          cfg_err;
    logic [15:0]   video_rgb_565;
    logic          video_hs;
    logic          video_vs;
    logic          video_de;
    logic [23:0]   video_rgb;
    logic          data_req;
    logic [CW-1:0] pixel_xpos;
    logic [CW-1:0] pixel_ypos;
    logic          frame_start;

    modport master (
        input  cfg_load, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
        input  cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front,
        input  video_rgb_565,
        output cfg_pending, cfg_err,
        output video_hs, video_vs, video_de, video_rgb,
        output data_req, pixel_xpos, pixel_ypos, frame_start
    );

    modport slave (
        output cfg_load, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
        output cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front,
        output video_rgb_565,
        input  cfg_pending, cfg_err,
        input  video_hs, video_vs, video_de, video_rgb,
        input  data_req, pixel_xpos, pixel_ypos, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable raster timing generator: HS/VS/DE, look-ahead pixel
// request with coordinates, and RGB565 to RGB888 expansion.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int REQ_LEAD = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter bit EXPAND   = 1'b0,
    parameter int H_SYNC   = 136,
    parameter int H_BACK   = 160,
    parameter int H_DISP   = 1024,
    parameter int H_FRONT  = 24,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29,
    parameter int V_DISP   = 768,
    parameter int V_FRONT  = 3
) (
    input  logic               pixel_clk,
    input  logic               sys_rst_n,
    video_timing_gen_if.master bus
);
    localparam int XW = CW + 2;

    typedef struct packed {
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_back;
        logic [CW-1:0] h_disp;
        logic [CW-1:0] h_front;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_back;
        logic [CW-1:0] v_disp;
        logic [CW-1:0] v_front;
    } timing_t;

    localparam timing_t RESET_TIMING = '{
        h_sync:  CW'(H_SYNC),
        h_back:  CW'(H_BACK),
        h_disp:  CW'(H_DISP),
        h_front: CW'(H_FRONT),
        v_sync:  CW'(V_SYNC),
        v_back:  CW'(V_BACK),
        v_disp:  CW'(V_DISP),
        v_front: CW'(V_FRONT)
    };

    timing_t       active;
    timing_t       shadow;
    timing_t       cfg_in;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [XW-1:0] h_total;
    logic [XW-1:0] v_total;
    logic [XW-1:0] h_start;
    logic [XW-1:0] h_end;
    logic [XW-1:0] v_start;
    logic [XW-1:0] v_end;
    logic [XW-1:0] h_ahead;
    logic [XW-1:0] cfg_h_total;
    logic [XW-1:0] cfg_v_total;
    logic          last_h;
    logic          last_v;
    logic          frame_wrap;
    logic          v_active;
    logic          de_now;
    logic          req_now;
    logic          cfg_ok;
    logic          pending;
    logic          err;
    logic          hs_q;
    logic          vs_q;
    logic          de_q;
    logic          req_q;
    logic          fs_q;
    logic [CW-1:0] xpos_q;
    logic [CW-1:0] ypos_q;
    logic [4:0]    red;
    logic [5:0]    green;
    logic [4:0]    blue;
    logic [23:0]   rgb_exp;

    function automatic logic [XW-1:0] ext(input logic [CW-1:0] a);
        return {2'b00, a};
    endfunction

    assign cfg_in = '{
        h_sync:  bus.cfg_h_sync,
        h_back:  bus.cfg_h_back,
        h_disp:  bus.cfg_h_disp,
        h_front: bus.cfg_h_front,
        v_sync:  bus.cfg_v_sync,
        v_back:  bus.cfg_v_back,
        v_disp:  bus.cfg_v_disp,
        v_front: bus.cfg_v_front
    };

    // h_back >= REQ_LEAD keeps every look-ahead that crosses a line or frame
    // boundary outside the active area, so the request needs no wrap logic.
    always_comb begin
        h_total    = ext(active.h_sync) + ext(active.h_back) + ext(active.h_disp) + ext(active.h_front);
        v_total    = ext(active.v_sync) + ext(active.v_back) + ext(active.v_disp) + ext(active.v_front);
        h_start    = ext(active.h_sync) + ext(active.h_back);
        h_end      = h_start + ext(active.h_disp);
        v_start    = ext(active.v_sync) + ext(active.v_back);
        v_end      = v_start + ext(active.v_disp);
        last_h     = (ext(h) == h_total - XW'(1));
        last_v     = (ext(v) == v_total - XW'(1));
        frame_wrap = last_h && last_v;
        h_ahead    = ext(h) + XW'(REQ_LEAD);
        v_active   = (ext(v) >= v_start) && (ext(v) < v_end);
        de_now     = (ext(h) >= h_start) && (ext(h) < h_end) && v_active;
        req_now    = (h_ahead >= h_start) && (h_ahead < h_end) && v_active;
    end

    always_comb begin
        cfg_h_total = ext(bus.cfg_h_sync) + ext(bus.cfg_h_back) + ext(bus.cfg_h_disp) + ext(bus.cfg_h_front);
        cfg_v_total = ext(bus.cfg_v_sync) + ext(bus.cfg_v_back) + ext(bus.cfg_v_disp) + ext(bus.cfg_v_front);
        cfg_ok      = (bus.cfg_h_sync != '0) && (bus.cfg_h_back != '0) && (bus.cfg_h_disp != '0) &&
                      (bus.cfg_v_sync != '0) && (bus.cfg_v_back != '0) && (bus.cfg_v_disp != '0) &&
                      (ext(bus.cfg_h_back) >= XW'(REQ_LEAD)) &&
                      (cfg_h_total[XW-1:CW] == 2'b00) && (cfg_v_total[XW-1:CW] == 2'b00);
    end

    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            h       <= '0;
            v       <= '0;
            active  <= RESET_TIMING;
            shadow  <= '0;
            pending <= 1'b0;
            err     <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
        end else begin
            if (last_h) begin
                h <= '0;
                v <= last_v ? '0 : v + CW'(1);
            end else begin
                h <= h + CW'(1);
            end

            // A load on the wrap edge still lets the previous shadow apply.
            if (frame_wrap && pending) begin
                active <= shadow;
            end
            if (bus.cfg_load && cfg_ok) begin
                shadow  <= cfg_in;
                pending <= 1'b1;
            end else if (frame_wrap) begin
                pending <= 1'b0;
            end
            err <= bus.cfg_load && !cfg_ok;

            hs_q   <= (h < active.h_sync) ? HS_POL : ~HS_POL;
            vs_q   <= (v < active.v_sync) ? VS_POL : ~VS_POL;
            de_q   <= de_now;
            req_q  <= req_now;
            fs_q   <= (h == '0) && (v == '0);
            xpos_q <= req_now ? CW'(h_ahead - h_start) : '0;
            ypos_q <= req_now ? CW'(ext(v) - v_start) : '0;
        end
    end

    always_comb begin
        red   = bus.video_rgb_565[15:11];
        green = bus.video_rgb_565[10:5];
        blue  = bus.video_rgb_565[4:0];
        if (EXPAND) begin
            rgb_exp = {red, red[4:2], green, green[5:4], blue, blue[4:2]};
        end else begin
            rgb_exp = {red, 3'b000, green, 2'b00, blue, 3'b000};
        end
    end

    assign bus.video_rgb   = de_q ? rgb_exp : 24'h000000;
    assign bus.video_hs    = hs_q;
    assign bus.video_vs    = vs_q;
    assign bus.video_de    = de_q;
    assign bus.data_req    = req_q;
    assign bus.pixel_xpos  = xpos_q;
    assign bus.pixel_ypos  = ypos_q;
    assign bus.frame_start = fs_q;
    assign bus.cfg_pending = pending;
    assign bus.cfg_err     = err;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small-raster instances (lead 1 / zero-pad,
// lead 3 / replicate with positive syncs) checked against hand-computed vectors.
module tb_video_timing_gen;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   tbl_rgb;
    logic          src_mode;
    logic [CW-1:0] d1, d2, d3;
    int            checks = 0;
    int            fails  = 0;

    typedef struct {
        int          n;
        logic [15:0] rgb565;
        logic        hs, vs, de, req;
        int          x, y;
        logic        fs;
        logic [23:0] rgb_a, rgb_b;
    } vec_t;

    vec_t vecs[14];

    video_timing_gen_if #(.CW(CW)) aif ();
    video_timing_gen_if #(.CW(CW)) bif ();

    video_timing_gen #(
        .CW(CW), .REQ_LEAD(1), .HS_POL(1'b0), .VS_POL(1'b0), .EXPAND(1'b0),
        .H_SYNC(2), .H_BACK(3), .H_DISP(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1)
    ) dut_a (
        .pixel_clk(clk),
        .sys_rst_n(rst_n),
        .bus(aif)
    );

    video_timing_gen #(
        .CW(CW), .REQ_LEAD(3), .HS_POL(1'b1), .VS_POL(1'b1), .EXPAND(1'b1),
        .H_SYNC(2), .H_BACK(3), .H_DISP(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1)
    ) dut_b (
        .pixel_clk(clk),
        .sys_rst_n(rst_n),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // Models a source with three cycles of read latency on instance B.
    always @(posedge clk) begin
        d1 <= bif.pixel_xpos;
        d2 <= d1;
        d3 <= d2;
    end

    function automatic logic [15:0] src_fn(input logic [CW-1:0] x);
        return {x[4:0], x[5:0], x[4:0]} ^ 16'h5A5A;
    endfunction

    function automatic logic [23:0] exp_replicate(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    function automatic vec_t mk(input int n, input logic [15:0] p, input logic hs, input logic vs,
                                input logic de, input logic req, input int x, input int y,
                                input logic fs, input logic [23:0] ra, input logic [23:0] rb);
        vec_t t;
        t.n = n; t.rgb565 = p; t.hs = hs; t.vs = vs; t.de = de; t.req = req;
        t.x = x; t.y = y; t.fs = fs; t.rgb_a = ra; t.rgb_b = rb;
        return t;
    endfunction

    assign aif.video_rgb_565 = tbl_rgb;
    assign bif.video_rgb_565 = src_mode ? src_fn(d3) : tbl_rgb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input vec_t t);
        check_val($sformatf("n%0d a.hs", t.n), aif.video_hs, t.hs);
        check_val($sformatf("n%0d a.vs", t.n), aif.video_vs, t.vs);
        check_val($sformatf("n%0d a.de", t.n), aif.video_de, t.de);
        check_val($sformatf("n%0d a.req", t.n), aif.data_req, t.req);
        check_val($sformatf("n%0d a.xpos", t.n), aif.pixel_xpos, t.x);
        check_val($sformatf("n%0d a.ypos", t.n), aif.pixel_ypos, t.y);
        check_val($sformatf("n%0d a.fs", t.n), aif.frame_start, t.fs);
        check_val($sformatf("n%0d a.rgb", t.n), aif.video_rgb, t.rgb_a);
        check_val($sformatf("n%0d b.hs", t.n), bif.video_hs, {~t.hs});
        check_val($sformatf("n%0d b.vs", t.n), bif.video_vs, {~t.vs});
        check_val($sformatf("n%0d b.de", t.n), bif.video_de, t.de);
        check_val($sformatf("n%0d b.rgb", t.n), bif.video_rgb, t.rgb_b);
    endtask

    task automatic load_cfg(input logic [CW-1:0] hs, input logic [CW-1:0] hb, input logic [CW-1:0] hd,
                            input logic [CW-1:0] hf, input logic [CW-1:0] vs, input logic [CW-1:0] vb,
                            input logic [CW-1:0] vd, input logic [CW-1:0] vf);
        aif.cfg_h_sync = hs; aif.cfg_h_back = hb; aif.cfg_h_disp = hd; aif.cfg_h_front = hf;
        aif.cfg_v_sync = vs; aif.cfg_v_back = vb; aif.cfg_v_disp = vd; aif.cfg_v_front = vf;
        aif.cfg_load = 1'b1;
        tick();
        aif.cfg_load = 1'b0;
    endtask

    // Returns the pending flag two samples before frame_start, i.e. just before the wrap edge.
    task automatic wait_fs(input string tag, output logic pend_before);
        logic found = 1'b0;
        logic p1 = aif.cfg_pending;
        logic p2 = aif.cfg_pending;
        for (int i = 0; i < 300 && !found; i++) begin
            p2 = p1;
            p1 = aif.cfg_pending;
            tick();
            if (aif.frame_start) found = 1'b1;
        end
        check_val({tag, " frame_start seen"}, found, 1'b1);
        pend_before = p2;
    endtask

    // Starts at a frame_start sample and runs to the next one.
    task automatic measure_frame(input string tag, input int exp_period, input int exp_de, input int exp_first);
        int   cnt = 0;
        int   de_cnt = 0;
        int   first = -1;
        logic done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            cnt++;
            if (aif.video_de) begin
                de_cnt++;
                if (first < 0) first = cnt;
            end
            if (aif.frame_start) done = 1'b1;
        end
        check_val({tag, " timeout"}, done, 1'b1);
        check_val({tag, " period"}, cnt, exp_period);
        check_val({tag, " de count"}, de_cnt, exp_de);
        check_val({tag, " first de"}, first, exp_first);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " a.hs"}, aif.video_hs, 1'b1);
        check_val({tag, " a.vs"}, aif.video_vs, 1'b1);
        check_val({tag, " a.de"}, aif.video_de, 1'b0);
        check_val({tag, " a.req"}, aif.data_req, 1'b0);
        check_val({tag, " a.xpos"}, aif.pixel_xpos, 0);
        check_val({tag, " a.ypos"}, aif.pixel_ypos, 0);
        check_val({tag, " a.fs"}, aif.frame_start, 1'b0);
        check_val({tag, " a.pending"}, aif.cfg_pending, 1'b0);
        check_val({tag, " a.err"}, aif.cfg_err, 1'b0);
        check_val({tag, " a.rgb"}, aif.video_rgb, 24'h0);
        check_val({tag, " b.hs"}, bif.video_hs, 1'b0);
        check_val({tag, " b.vs"}, bif.video_vs, 1'b0);
        check_val({tag, " b.rgb"}, bif.video_rgb, 24'h0);
    endtask

    initial begin
        int          vi;
        int          elapsed;
        int          cnt;
        int          de_idx;
        int          req_idx;
        int          first_req;
        logic        done;
        logic        pend_before;
        logic [23:0] exp_rgb;

        // Default raster: HT=10, VT=5; hs h<2, vs v<1, DE h 5..8 on lines 2..3.
        vecs[0]  = mk( 1, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 24'h000000, 24'h000000);
        vecs[1]  = mk( 2, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[2]  = mk( 3, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[3]  = mk(11, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[4]  = mk(25, 16'hFFFF, 1, 1, 0, 1, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[5]  = mk(26, 16'hFFFF, 1, 1, 1, 1, 1, 0, 0, 24'hF8FCF8, 24'hFFFFFF);
        vecs[6]  = mk(29, 16'h8410, 1, 1, 1, 0, 0, 0, 0, 24'h808080, 24'h848284);
        vecs[7]  = mk(30, 16'hFFFF, 1, 1, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[8]  = mk(36, 16'h1234, 1, 1, 1, 1, 1, 1, 0, 24'h1044A0, 24'h1045A5);
        vecs[9]  = mk(38, 16'h0000, 1, 1, 1, 1, 3, 1, 0, 24'h000000, 24'h000000);
        vecs[10] = mk(40, 16'hFFFF, 1, 1, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[11] = mk(45, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[12] = mk(50, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 24'h000000, 24'h000000);
        vecs[13] = mk(51, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 24'h000000, 24'h000000);

        rst_n    = 1'b0;
        src_mode = 1'b0;
        tbl_rgb  = 16'hFFFF;
        aif.cfg_load = 1'b0;
        aif.cfg_h_sync = '0; aif.cfg_h_back = '0; aif.cfg_h_disp = '0; aif.cfg_h_front = '0;
        aif.cfg_v_sync = '0; aif.cfg_v_back = '0; aif.cfg_v_disp = '0; aif.cfg_v_front = '0;
        bif.cfg_load = 1'b0;
        bif.cfg_h_sync = '0; bif.cfg_h_back = '0; bif.cfg_h_disp = '0; bif.cfg_h_front = '0;
        bif.cfg_v_sync = '0; bif.cfg_v_back = '0; bif.cfg_v_disp = '0; bif.cfg_v_front = '0;
        repeat (3) tick();
        check_reset_state("reset");

        $display("[TB] table vectors, first frames after reset");
        rst_n = 1'b1;
        vi = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            tbl_rgb = (vi < 14 && vecs[vi].n == n) ? vecs[vi].rgb565 : 16'h0000;
            #1;
            if (vi < 14 && vecs[vi].n == n) begin
                check_output(vecs[vi]);
                vi++;
            end
        end

        $display("[TB] lead-3 source tracking on instance B");
        src_mode = 1'b1;
        tbl_rgb  = 16'h0000;
        wait_fs("b sync", pend_before);
        cnt = 0; de_idx = 0; req_idx = 0; first_req = -1; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            cnt++;
            if (bif.frame_start) begin
                done = 1'b1;
            end else begin
                exp_rgb = bif.video_de ? exp_replicate(src_fn(CW'(de_idx % 4))) : 24'h0;
                check_val($sformatf("b.rgb c%0d", cnt), bif.video_rgb, exp_rgb);
                if (bif.video_de) de_idx++;
                if (bif.data_req) begin
                    if (first_req < 0) first_req = cnt;
                    check_val($sformatf("b.xpos r%0d", req_idx), bif.pixel_xpos, req_idx % 4);
                    check_val($sformatf("b.ypos r%0d", req_idx), bif.pixel_ypos, req_idx / 4);
                    req_idx++;
                end
            end
        end
        check_val("b frame done", done, 1'b1);
        check_val("b period", cnt, 50);
        check_val("b de count", de_idx, 8);
        check_val("b req count", req_idx, 8);
        check_val("b first req", first_req, 22);

        measure_frame("default", 50, 8, 25);

        $display("[TB] mid-frame reconfiguration");
        repeat (9) tick();
        load_cfg(2, 3, 8, 2, 1, 2, 4, 1);
        check_val("load1 pending", aif.cfg_pending, 1'b1);
        check_val("load1 err", aif.cfg_err, 1'b0);
        wait_fs("load1 wrap", pend_before);
        check_val("pending before wrap", pend_before, 1'b1);
        check_val("pending after wrap", aif.cfg_pending, 1'b0);
        measure_frame("15x8", 120, 32, 50);

        $display("[TB] rejected configurations");
        load_cfg(2, 3, 0, 2, 1, 2, 4, 1);
        check_val("bad disp err", aif.cfg_err, 1'b1);
        check_val("bad disp pending", aif.cfg_pending, 1'b0);
        tick();
        check_val("err one cycle", aif.cfg_err, 1'b0);
        load_cfg(2, 0, 8, 2, 1, 2, 4, 1);
        check_val("bad back err", aif.cfg_err, 1'b1);
        check_val("bad back pending", aif.cfg_pending, 1'b0);
        wait_fs("after bad", pend_before);
        measure_frame("unchanged", 120, 32, 50);

        $display("[TB] last-valid-wins and wrap-edge load");
        repeat (5) tick();
        load_cfg(2, 1, 4, 1, 1, 1, 2, 1);
        check_val("x pending", aif.cfg_pending, 1'b1);
        load_cfg(2, 1, 0, 1, 1, 1, 2, 1);
        check_val("bad while pending err", aif.cfg_err, 1'b1);
        check_val("bad while pending keeps", aif.cfg_pending, 1'b1);
        load_cfg(1, 2, 3, 1, 1, 1, 3, 1);
        check_val("y err", aif.cfg_err, 1'b0);
        elapsed = 8;
        repeat (118 - elapsed) tick();
        load_cfg(1, 1, 1, 1, 1, 1, 1, 1);
        check_val("z pending on wrap", aif.cfg_pending, 1'b1);
        tick();
        check_val("y frame start", aif.frame_start, 1'b1);
        measure_frame("y frame", 42, 9, 17);
        check_val("z applied pending clear", aif.cfg_pending, 1'b0);
        measure_frame("z frame", 16, 1, 10);

        $display("[TB] reset mid-line");
        load_cfg(1, 2, 3, 1, 1, 1, 3, 1);
        check_val("pre-reset pending", aif.cfg_pending, 1'b1);
        repeat (3) tick();
        rst_n   = 1'b0;
        tbl_rgb = 16'hFFFF;
        tick();
        check_reset_state("mid reset");
        rst_n = 1'b1;
        tick();
        check_val("release a.fs", aif.frame_start, 1'b1);
        check_val("release a.hs", aif.video_hs, 1'b0);
        check_val("release a.vs", aif.video_vs, 1'b0);
        check_val("release b.fs", bif.frame_start, 1'b1);
        measure_frame("after reset", 50, 8, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
